// File: rtl/ip_tx_framer.sv
// Framer from the ROS2 core's serialized TX byte stream to the verilog-ethernet IP TX header and
// payload interfaces. Optional length check is enabled by defining IP_TX_FRAMER_LEN_CHECK_EN.
module ip_tx_framer #(
  parameter int unsigned MAX_PAYLOAD = 1472
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din_dout,
  input  logic        din_empty_n,
  output logic        din_read,
  output logic        tx_hdr_valid,
  input  logic        tx_hdr_ready,
  output logic [5:0]  tx_ip_dscp,
  output logic [1:0]  tx_ip_ecn,
  output logic [15:0] tx_ip_length,
  output logic [7:0]  tx_ip_ttl,
  output logic [7:0]  tx_ip_protocol,
  output logic [31:0] tx_ip_source_ip,
  output logic [31:0] tx_ip_dest_ip,
  output logic [7:0]  tx_payload_tdata,
  output logic        tx_payload_tvalid,
  input  logic        tx_payload_tready,
  output logic        tx_payload_tlast,
  output logic        busy,
  output logic [15:0] drop_count
);

`ifdef IP_TX_FRAMER_LEN_CHECK_EN
  localparam bit LenCheckEn = 1'b1;
`else
  localparam bit LenCheckEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StSendHdr,
    StPayload,
    StDrop
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] dest_q, dest_d;
  logic [31:0] src_q, src_d;
  logic [7:0]  proto_q, proto_d;
  logic [7:0]  ttl_q, ttl_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] ip_len_q, ip_len_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] drop_q, drop_d;

  logic        din_read_c;
  logic [15:0] len_val;
  logic        len_zero;
  logic        len_over;
  logic [15:0] drop_inc;

  assign len_val  = {len_hi_q, din_dout};
  assign len_zero = (len_val == 16'd0);
  assign len_over = ({16'd0, len_val} > MAX_PAYLOAD);
  assign drop_inc = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    dest_d            = dest_q;
    src_d             = src_q;
    proto_d           = proto_q;
    ttl_d             = ttl_q;
    len_hi_d          = len_hi_q;
    ip_len_d          = ip_len_q;
    rem_d             = rem_q;
    drop_d            = drop_q;
    din_read_c        = 1'b0;
    tx_hdr_valid      = 1'b0;
    tx_payload_tvalid = 1'b0;
    tx_payload_tdata  = 8'h00;
    tx_payload_tlast  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Byte 0 is taken in the same cycle the frame is noticed.
        if (din_empty_n) begin
          din_read_c = 1'b1;
          dest_d     = {dest_q[23:0], din_dout};
          idx_d      = 4'd1;
          state_d    = StHdr;
        end
      end

      StHdr: begin
        din_read_c = din_empty_n;
        if (din_empty_n) begin
          idx_d = idx_q + 4'd1;
          case (idx_q)
            4'd0, 4'd1, 4'd2, 4'd3: dest_d = {dest_q[23:0], din_dout};
            4'd4, 4'd5, 4'd6, 4'd7: src_d  = {src_q[23:0], din_dout};
            4'd8:  proto_d  = din_dout;
            4'd9:  ttl_d    = din_dout;
            4'd10: len_hi_d = din_dout;
            4'd11: begin
              idx_d    = 4'd0;
              ip_len_d = len_val + 16'd20;
              rem_d    = len_val;
              if (LenCheckEn && len_zero) begin
                drop_d  = drop_inc;
                state_d = StIdle;
              end else if (LenCheckEn && len_over) begin
                state_d = StDrop;
              end else begin
                state_d = StSendHdr;
              end
            end
            default: idx_d = 4'd0;
          endcase
        end
      end

      StSendHdr: begin
        tx_hdr_valid = 1'b1;
        if (tx_hdr_ready) begin
          state_d = (rem_q == 16'd0) ? StIdle : StPayload;
        end
      end

      StPayload: begin
        // Zero-latency pass-through; tvalid follows FIFO occupancy.
        tx_payload_tvalid = din_empty_n;
        tx_payload_tdata  = din_dout;
        tx_payload_tlast  = (rem_q == 16'd1);
        din_read_c        = din_empty_n & tx_payload_tready;
        if (din_read_c) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = StIdle;
          end
        end
      end

      StDrop: begin
        din_read_c = din_empty_n;
        if (din_empty_n) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            drop_d  = drop_inc;
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= 4'd0;
      dest_q   <= 32'd0;
      src_q    <= 32'd0;
      proto_q  <= 8'd0;
      ttl_q    <= 8'd0;
      len_hi_q <= 8'd0;
      ip_len_q <= 16'd0;
      rem_q    <= 16'd0;
      drop_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dest_q   <= dest_d;
      src_q    <= src_d;
      proto_q  <= proto_d;
      ttl_q    <= ttl_d;
      len_hi_q <= len_hi_d;
      ip_len_q <= ip_len_d;
      rem_q    <= rem_d;
      drop_q   <= drop_d;
    end
  end

  // IDLE reads combinationally from the FIFO flag, so mask it while reset is held.
  assign din_read        = din_read_c & ~rst;
  assign busy            = (state_q != StIdle);
  assign drop_count      = LenCheckEn ? drop_q : 16'd0;
  assign tx_ip_dscp      = 6'd0;
  assign tx_ip_ecn       = 2'd0;
  assign tx_ip_length    = ip_len_q;
  assign tx_ip_ttl       = ttl_q;
  assign tx_ip_protocol  = proto_q;
  assign tx_ip_source_ip = src_q;
  assign tx_ip_dest_ip   = dest_q;

endmodule

// File: tb/tb_ip_tx_framer.sv
// Directed bench for ip_tx_framer: FIFO model feeds frames, a monitor captures header and payload
// handshakes, and each test compares them against hand-computed values.
module tb_ip_tx_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din_dout;
  logic        din_empty_n;
  logic        din_read;
  logic        tx_hdr_valid;
  logic        tx_hdr_ready;
  logic [5:0]  tx_ip_dscp;
  logic [1:0]  tx_ip_ecn;
  logic [15:0] tx_ip_length;
  logic [7:0]  tx_ip_ttl;
  logic [7:0]  tx_ip_protocol;
  logic [31:0] tx_ip_source_ip;
  logic [31:0] tx_ip_dest_ip;
  logic [7:0]  tx_payload_tdata;
  logic        tx_payload_tvalid;
  logic        tx_payload_tready;
  logic        tx_payload_tlast;
  logic        busy;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  ip_tx_framer #(.MAX_PAYLOAD(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .din_dout         (din_dout),
    .din_empty_n      (din_empty_n),
    .din_read         (din_read),
    .tx_hdr_valid     (tx_hdr_valid),
    .tx_hdr_ready     (tx_hdr_ready),
    .tx_ip_dscp       (tx_ip_dscp),
    .tx_ip_ecn        (tx_ip_ecn),
    .tx_ip_length     (tx_ip_length),
    .tx_ip_ttl        (tx_ip_ttl),
    .tx_ip_protocol   (tx_ip_protocol),
    .tx_ip_source_ip  (tx_ip_source_ip),
    .tx_ip_dest_ip    (tx_ip_dest_ip),
    .tx_payload_tdata (tx_payload_tdata),
    .tx_payload_tvalid(tx_payload_tvalid),
    .tx_payload_tready(tx_payload_tready),
    .tx_payload_tlast (tx_payload_tlast),
    .busy             (busy),
    .drop_count       (drop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model: first-word-fall-through, popped just after the edge that saw din_read.
  logic [7:0] fifo[$];
  logic       stall = 1'b0;
  bit         stall_mode = 1'b0;
  bit         tready_toggle = 1'b0;
  logic       rd_s = 1'b0;
  int         cyc = 0;

  task automatic fifo_drive();
    din_empty_n = (fifo.size() != 0) && !stall;
    din_dout    = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rd_s && !rst && fifo.size() != 0) void'(fifo.pop_front());
    stall = stall_mode && (cyc % 3 == 1);
    tx_payload_tready = tready_toggle ? ~tx_payload_tready : 1'b1;
    fifo_drive();
  end

  // Monitor: samples mid-cycle, records handshakes, checks per-cycle protocol rules.
  logic [95:0] hdrs[$];
  int          hdr_cyc[$];
  logic [8:0]  beats[$];
  int          beat_cyc[$];
  int          idle_rd[$];
  logic [95:0] prev_hdr;
  logic        prev_wait = 1'b0;

  always @(negedge clk) begin
    logic [95:0] cur;
    cur  = {tx_ip_dest_ip, tx_ip_source_ip, tx_ip_protocol, tx_ip_ttl, tx_ip_length};
    rd_s = din_read;
    if (!rst) begin
      check_eq("rd_needs_data", din_read & ~din_empty_n, 0);
      check_eq("no_overlap", tx_hdr_valid & tx_payload_tvalid, 0);
      check_eq("tvalid_empty", tx_payload_tvalid & ~din_empty_n, 0);
      check_eq("dscp_ecn", {tx_ip_dscp, tx_ip_ecn}, 0);
      if (prev_wait) begin
        check_eq("hdr_valid_hold", tx_hdr_valid, 1);
        check_eq("hdr_fields_hold", cur, prev_hdr);
      end
      prev_wait = tx_hdr_valid & ~tx_hdr_ready;
      prev_hdr  = cur;
      if (tx_hdr_valid && tx_hdr_ready) begin
        hdrs.push_back(cur);
        hdr_cyc.push_back(cyc);
      end
      if (tx_payload_tvalid && tx_payload_tready) begin
        beats.push_back({tx_payload_tlast, tx_payload_tdata});
        beat_cyc.push_back(cyc);
      end
      if (din_read && !busy) idle_rd.push_back(cyc);
    end else begin
      prev_wait = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_frame(input logic [31:0] d, input logic [31:0] s, input logic [7:0] p,
                            input logic [7:0] t, input logic [15:0] l, input logic [7:0] seed,
                            input int npay);
    logic [7:0] b;
    for (int i = 3; i >= 0; i--) fifo.push_back(d[i*8+:8]);
    for (int i = 3; i >= 0; i--) fifo.push_back(s[i*8+:8]);
    fifo.push_back(p);
    fifo.push_back(t);
    fifo.push_back(l[15:8]);
    fifo.push_back(l[7:0]);
    b = seed;
    for (int i = 0; i < npay; i++) begin
      fifo.push_back(b);
      b = b + 8'h11;
    end
    fifo_drive();
  endtask

  // Payload byte i of a frame is seed + 0x11*i; tlast expected on the final byte only.
  task automatic expect_frame(input string tag, input logic [31:0] d, input logic [31:0] s,
                              input logic [7:0] p, input logic [7:0] t, input logic [15:0] l,
                              input logic [7:0] seed, output int hcyc, output int tcyc);
    int         n;
    logic [7:0] b;
    logic [15:0] exp_len;
    n    = 0;
    hcyc = -1;
    tcyc = -1;
    while ((hdrs.size() == 0 || beats.size() < int'(l)) && n < 400) begin
      step(1);
      n++;
    end
    check_eq({tag, "_in_time"}, n < 400, 1);
    exp_len = l + 16'd20;
    if (hdrs.size() != 0) begin
      check_eq({tag, "_hdr"}, hdrs.pop_front(), {d, s, p, t, exp_len});
      hcyc = hdr_cyc.pop_front();
    end
    b = seed;
    for (int i = 0; i < int'(l); i++) begin
      if (beats.size() != 0) begin
        check_eq({tag, "_beat"}, beats.pop_front(), {(i == int'(l) - 1), b});
        tcyc = beat_cyc.pop_front();
      end
      b = b + 8'h11;
    end
  endtask

  localparam logic [31:0] Dst = 32'hC0A8_0101;
  localparam logic [31:0] Src = 32'hC0A8_0164;

  initial begin
    int hc, tc, hc2, tc2, start, n;
    rst               = 1'b1;
    tx_hdr_ready      = 1'b1;
    tx_payload_tready = 1'b1;
    fifo_drive();
    step(2);

    // Reset state, with a frame already waiting in the FIFO.
    push_frame(Dst, Src, 8'd17, 8'd64, 16'd4, 8'hAA, 4);
    #1;
    check_eq("rst_din_read", din_read, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valids", {tx_hdr_valid, tx_payload_tvalid, tx_payload_tlast}, 0);
    check_eq("rst_tdata", tx_payload_tdata, 0);
    check_eq("rst_hdr_fields",
             {tx_ip_dest_ip, tx_ip_source_ip, tx_ip_protocol, tx_ip_ttl, tx_ip_length}, 0);
    check_eq("rst_drop_count", drop_count, 0);
    rst   = 1'b0;
    start = cyc;

    // Single frame: 12 header + 1 SEND_HDR + 4 payload cycles.
    expect_frame("single", Dst, Src, 8'd17, 8'd64, 16'd4, 8'hAA, hc, tc);
    check_eq("single_hdr_latency", hc - start, 12);
    check_eq("single_frame_time", tc - start + 1, 17);
    step(2);

    // Back-pressure: header held 5 cycles, payload ready toggling.
    tx_hdr_ready  = 1'b0;
    tready_toggle = 1'b1;
    push_frame(32'h0A00_0001, 32'h0A00_0002, 8'd6, 8'd32, 16'd5, 8'h31, 5);
    n = 0;
    while (!tx_hdr_valid && n < 50) begin
      step(1);
      n++;
    end
    check_eq("bp_hdr_seen", tx_hdr_valid, 1);
    start = cyc;
    step(5);
    tx_hdr_ready = 1'b1;
    expect_frame("bp", 32'h0A00_0001, 32'h0A00_0002, 8'd6, 8'd32, 16'd5, 8'h31, hc, tc);
    check_eq("bp_hdr_wait", hc - start, 5);
    tready_toggle = 1'b0;
    step(3);

    // FIFO underrun in header and payload phases.
    stall_mode = 1'b1;
    start      = cyc;
    push_frame(32'h0102_0304, 32'h0506_0708, 8'd1, 8'd255, 16'd3, 8'h51, 3);
    expect_frame("underrun", 32'h0102_0304, 32'h0506_0708, 8'd1, 8'd255, 16'd3, 8'h51, hc, tc);
    check_eq("underrun_stalled", (tc - start + 1) > 16, 1);
    stall_mode = 1'b0;
    step(3);

    // Back-to-back frames.
    idle_rd.delete();
    push_frame(Dst, Src, 8'd17, 8'd1, 16'd1, 8'h10, 1);
    push_frame(Src, Dst, 8'd17, 8'd2, 16'd2, 8'h20, 2);
    expect_frame("b2b_a", Dst, Src, 8'd17, 8'd1, 16'd1, 8'h10, hc, tc);
    expect_frame("b2b_b", Src, Dst, 8'd17, 8'd2, 16'd2, 8'h20, hc2, tc2);
    check_eq("b2b_idle_reads", idle_rd.size(), 2);
    if (idle_rd.size() == 2) check_eq("b2b_next_read", idle_rd[1], tc + 1);
    step(3);

`ifdef IP_TX_FRAMER_LEN_CHECK_EN
    // L=0 and L=9 dropped (MAX_PAYLOAD=8), L=2 emitted.
    push_frame(Dst, Src, 8'd17, 8'd9, 16'd0, 8'h00, 0);
    push_frame(Dst, Src, 8'd17, 8'd9, 16'd9, 8'h61, 9);
    push_frame(Dst, Src, 8'd17, 8'd9, 16'd2, 8'h71, 2);
    expect_frame("lenchk", Dst, Src, 8'd17, 8'd9, 16'd2, 8'h71, hc, tc);
    step(3);
    check_eq("lenchk_drops", drop_count, 2);
    check_eq("lenchk_drained", fifo.size(), 0);
    check_eq("lenchk_extra_hdr", hdrs.size(), 0);
    check_eq("lenchk_extra_beats", beats.size(), 0);
`else
    // No length check: L=0 gives a header-only transaction.
    push_frame(Dst, Src, 8'd17, 8'd9, 16'd0, 8'h00, 0);
    push_frame(Dst, Src, 8'd17, 8'd9, 16'd2, 8'h71, 2);
    expect_frame("len0", Dst, Src, 8'd17, 8'd9, 16'd0, 8'h00, hc, tc);
    expect_frame("len2", Dst, Src, 8'd17, 8'd9, 16'd2, 8'h71, hc, tc);
    step(3);
    check_eq("len0_drops", drop_count, 0);
    check_eq("len0_extra_beats", beats.size(), 0);

    // Length wraps modulo 2^16; abandoned by reset while the header waits.
    tx_hdr_ready = 1'b0;
    push_frame(Dst, Src, 8'd17, 8'd9, 16'hFFF0, 8'h00, 0);
    n = 0;
    while (!tx_hdr_valid && n < 50) begin
      step(1);
      n++;
    end
    check_eq("wrap_hdr_seen", tx_hdr_valid, 1);
    check_eq("wrap_length", tx_ip_length, 16'h0004);
    rst = 1'b1;
    fifo.delete();
    fifo_drive();
    #1;
    check_eq("wrap_rst_valid", tx_hdr_valid, 0);
    step(1);
    rst          = 1'b0;
    tx_hdr_ready = 1'b1;
    step(1);
`endif

    // Reset during payload byte 2 of L=10.
    push_frame(Dst, Src, 8'd17, 8'd64, 16'd10, 8'h81, 10);
    n = 0;
    while (beats.size() < 2 && n < 100) begin
      step(1);
      n++;
    end
    check_eq("mid_rst_progress", beats.size(), 2);
    check_eq("mid_rst_pre_tvalid", tx_payload_tvalid, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_din_read", din_read, 0);
    check_eq("mid_rst_valids", {tx_hdr_valid, tx_payload_tvalid, tx_payload_tlast}, 0);
    check_eq("mid_rst_tdata", tx_payload_tdata, 0);
    check_eq("mid_rst_hdr_fields",
             {tx_ip_dest_ip, tx_ip_source_ip, tx_ip_protocol, tx_ip_ttl, tx_ip_length}, 0);
    fifo.delete();
    beats.delete();
    beat_cyc.delete();
    hdrs.delete();
    hdr_cyc.delete();
    fifo_drive();
    step(2);
    rst = 1'b0;
    push_frame(Src, Dst, 8'd17, 8'd128, 16'd2, 8'h91, 2);
    expect_frame("post_rst", Src, Dst, 8'd17, 8'd128, 16'd2, 8'h91, hc, tc);
    step(2);
    check_eq("post_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/ip_tx_framer.md
# ip_tx_framer

Converts the serialized transmit byte stream produced by the ROS2 core's `out_V` port into the header/payload interface of the verilog-ethernet IP transmit path. The block sits between the 8-bit TX FIFO (read side) and the `tx_ip_*` header and AXI-Stream payload inputs of the Ethernet/IP stack, and replaces a vendor-generated equivalent with hand-written RTL.

## Interface
Parameters:
- `MAX_PAYLOAD`, default 1472: largest legal payload length L in bytes. Used only when `IP_TX_FRAMER_LEN_CHECK_EN` is defined.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-high reset.
- `din_dout` in 8: FIFO head byte. First-word-fall-through: valid whenever `din_empty_n`=1.
- `din_empty_n` in 1: FIFO holds at least one byte.
- `din_read` out 1: pops the head byte in the cycle it is high. Only high when `din_empty_n`=1.
- `tx_hdr_valid` out 1: IP header fields are valid.
- `tx_hdr_ready` in 1: the stack accepts the header.
- `tx_ip_dscp` out 6: constant 0.
- `tx_ip_ecn` out 2: constant 0.
- `tx_ip_length` out 16: IP total length, equal to L+20.
- `tx_ip_ttl` out 8: TTL.
- `tx_ip_protocol` out 8: protocol number.
- `tx_ip_source_ip` out 32: source address.
- `tx_ip_dest_ip` out 32: destination address.
- `tx_payload_tdata` out 8: payload byte.
- `tx_payload_tvalid` out 1: payload byte is valid.
- `tx_payload_tready` in 1: the stack accepts the payload byte.
- `tx_payload_tlast` out 1: marks the last payload byte.
- `busy` out 1: high whenever the state is not IDLE.
- `drop_count` out 16: count of discarded frames. Saturates at 0xFFFF.

## Operation
Input frame format, in order:
- Bytes 0-3: dest_ip, MSB first.
- Bytes 4-7: source_ip, MSB first.
- Byte 8: protocol.
- Byte 9: ttl.
- Bytes 10-11: payload length L, 16-bit big-endian.
- Then L payload bytes.

State machine:
- **IDLE → HDR:** when `din_empty_n`=1. The first header byte is consumed in the same cycle.
- **HDR:** `din_read` = `din_empty_n`. A 4-bit index counts 0..11, and each byte is written into its header register. Empty cycles stall the index.
  - On byte 11: go to DROP if the check fails (see Configuration); otherwise go to SEND_HDR.
- **SEND_HDR:** `tx_hdr_valid`=1, with all header outputs held stable until `tx_hdr_ready`=1.
  - After the handshake: go to PAYLOAD with a 16-bit remaining count of L; if L=0, go to IDLE.
  - No bytes are read from the FIFO in SEND_HDR.
- **PAYLOAD:** combinational pass-through.
  - `tx_payload_tvalid` = `din_empty_n`.
  - `tx_payload_tdata` = `din_dout`.
  - `din_read` = tvalid & tready.
  - `tx_payload_tlast` = (remaining==1).
  - Each transfer decrements remaining. The transfer with tlast returns the block to IDLE.
- **DROP:** `din_read` = `din_empty_n`, with no output activity. Consume L bytes, increment `drop_count`, then go to IDLE.

Arithmetic:
- `tx_ip_length` = L + 20, computed modulo 2^16.

## Timing
- Reset values:
  - All `tx_*` outputs are 0, including `tx_hdr_valid`, `tx_payload_tvalid` and `tx_payload_tlast`.
  - `din_read`=0, `busy`=0, `drop_count`=0, state=IDLE.
- Minimum frame time with a full FIFO and ready always high: 12 header cycles + 1 SEND_HDR cycle + L payload cycles. The next frame's byte 0 may be read in the cycle after tlast.
- `tx_hdr_valid` rises 1 cycle after byte 11 is consumed.
- Payload latency is 0 cycles from the FIFO head to `tx_payload_tdata`.
- Handshake rules:
  - Valid outputs never drop without a handshake, except on a FIFO underrun in PAYLOAD. In that case `tx_payload_tvalid` falls, which AXI-Stream permits only because no transfer has been offered; tdata/tlast stay consistent with the head byte.
  - The header and payload phases never overlap.
- Reset mid-frame: returns to IDLE immediately. The producer and FIFO share `rst`, so no partial frame survives reset.

## Configuration
Macro: `IP_TX_FRAMER_LEN_CHECK_EN`.
- **Defined:**
  - A header with L=0 or L>`MAX_PAYLOAD` does not produce `tx_hdr_valid`.
  - L=0 returns to IDLE after byte 11; L>`MAX_PAYLOAD` goes through DROP.
  - Both cases increment `drop_count`.
- **Not defined:**
  - No check is made. L=0 produces a header-only transaction with no payload beats.
  - `drop_count` is tied to 0 and DROP is unreachable.

## Test plan
- **Single frame:** header dest 192.168.1.1, source 192.168.1.100, protocol 17, ttl 64, L=4, payload AA BB CC DD, with ready held high. Expected: a header with `tx_ip_length`=24, then 4 beats AA..DD with tlast on DD; total time 17 cycles.
- **Back-pressure:** `tx_hdr_ready` low for 5 cycles, then `tx_payload_tready` toggling 1/0. Expected: header fields stable while waiting, no byte lost or duplicated, and `din_read` only on handshake cycles.
- **FIFO underrun:** empty cycles inserted in both the header and payload phases for L=3. Expected: the header index stalls, tvalid drops during empty cycles, and the output bytes are correct.
- **Back-to-back frames:** two frames with L=1 and L=2. Expected: the second frame's byte 0 is read in the cycle after the first frame's tlast, with correct tlast on both.
- **Length check (macro defined, `MAX_PAYLOAD`=8):** frames with L=0, L=9 and L=2. Expected: `drop_count`=2, the 9 bytes are drained, and only the L=2 frame is emitted.
- **Mid-payload reset:** assert `rst` during byte 2 of L=10. Expected: all outputs go to 0 asynchronously, `busy`=0, and a fresh frame after reset is emitted correctly.
